bank_isu_dispatch_sched: RTL and testbench

Per-bank dispatch scheduler between the issue-queue credit manager and the bank command bus. Each cycle it takes one credit-allowed candidate per channel, picks one round-robin, and drives a registered valid/ready issue port. It dequeues the issued entry from the IQ, tracks outstanding reads per channel, and turns read responses into one-cycle `channels_credit_release` pulses back to the credit manager. A drain sequence lets the bank controller quiesce all traffic.

---
 rtl/bank_isu_pkg.sv | 16 +
 rtl/bank_isu_dispatch_sched_if.sv | 35 +++
 rtl/rr_arb.sv | 25 ++
 rtl/bank_isu_dispatch_sched.sv | 154 +++++++++++++++
 tb/tb_bank_isu_dispatch_sched.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_isu_pkg.sv
// Shared types and sizing for the bank issue-queue dispatch path.
package bank_isu_pkg;
    localparam int unsigned CHANNEL_NUM     = 3;
    localparam int unsigned PTR_WIDTH       = 8;
    localparam int unsigned MAX_OUTSTANDING = 8;
    localparam int unsigned CNT_WIDTH       = 4;

    typedef logic [1:0]           ch_id_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } dsp_state_e;
endpackage

// File: rtl/bank_isu_dispatch_sched_if.sv
// Candidate, issue, response and drain signals between the scheduler and its neighbours.
interface bank_isu_dispatch_sched_if;
    import bank_isu_pkg::*;

    logic [CHANNEL_NUM-1:0]           ch_req_valid;
    logic [CHANNEL_NUM*PTR_WIDTH-1:0] ch_req_ptr;
    logic [CHANNEL_NUM-1:0]           ch_req_is_read;
    logic                             iss_valid;
    logic                             iss_ready;
    logic [PTR_WIDTH-1:0]             iss_ptr;
    ch_id_t                           iss_ch_id;
    logic                             iss_is_read;
    logic                             iq_dequeue;
    logic [PTR_WIDTH-1:0]             iq_dequeue_ptr;
    logic                             rsp_valid;
    ch_id_t                           rsp_ch_id;
    logic [CHANNEL_NUM-1:0]           channels_credit_release;
    logic                             drain_req;
    logic                             drain_done;
    logic                             err_underflow;

    modport master (
        input  ch_req_valid, ch_req_ptr, ch_req_is_read, iss_ready, rsp_valid, rsp_ch_id,
               drain_req,
        output iss_valid, iss_ptr, iss_ch_id, iss_is_read, iq_dequeue, iq_dequeue_ptr,
               channels_credit_release, drain_done, err_underflow
    );

    modport slave (
        output ch_req_valid, ch_req_ptr, ch_req_is_read, iss_ready, rsp_valid, rsp_ch_id,
               drain_req,
        input  iss_valid, iss_ptr, iss_ch_id, iss_is_read, iq_dequeue, iq_dequeue_ptr,
               channels_credit_release, drain_done, err_underflow
    );
endinterface

// File: rtl/rr_arb.sv
// Combinational N-way round-robin arbiter: first requester at or after ptr wins.
module rr_arb #(
    parameter int unsigned N    = 3,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    gnt
);
    int unsigned idx;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bank_isu_dispatch_sched.sv
// Per-bank dispatch scheduler: round-robin issue of credit-allowed candidates, outstanding
// read tracking, credit-release pulses and a drain sequence.
module bank_isu_dispatch_sched
    import bank_isu_pkg::*;
(
    input logic                        clk,
    input logic                        rst_n,
    bank_isu_dispatch_sched_if.master  bus
);
    localparam logic [1:0] StIdle  = 2'(IDLE);
    localparam logic [1:0] StHold  = 2'(HOLD);
    localparam logic [1:0] StDrain = 2'(DRAIN);

    logic [1:0]             state_q, state_d;
    logic                   iss_valid_q, iss_valid_d;
    logic [PTR_WIDTH-1:0]   iss_ptr_q, iss_ptr_d;
    ch_id_t                 iss_ch_id_q, iss_ch_id_d;
    logic                   iss_is_read_q, iss_is_read_d;
    ch_id_t                 rr_ptr_q, rr_ptr_d;
    cnt_t                   outst_q [CHANNEL_NUM];
    cnt_t                   outst_d [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0] release_q;
    logic                   err_q, err_d;

    logic                   hs, arb_en, any_gnt, all_idle, drain_done_c;
    logic [CHANNEL_NUM-1:0] elig, gnt, inc_vec, rsp_vec;
    ch_id_t                 win;

    assign hs = iss_valid_q & bus.iss_ready;

    // The channel handshaking now is masked: its IQ entry leaves at this same edge.
    always_comb begin
        elig = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            elig[c] = bus.ch_req_valid[c]
                    & ~(hs & (iss_ch_id_q == ch_id_t'(c)))
                    & (~bus.ch_req_is_read[c] | (outst_q[c] < cnt_t'(MAX_OUTSTANDING)));
        end
    end

    rr_arb #(.N(CHANNEL_NUM)) u_rr_arb (
        .req (elig),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        win = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (gnt[c]) win = ch_id_t'(c);
        end
    end
    assign any_gnt = |gnt;

    always_comb begin
        state_d       = state_q;
        iss_valid_d   = iss_valid_q;
        iss_ptr_d     = iss_ptr_q;
        iss_ch_id_d   = iss_ch_id_q;
        iss_is_read_d = iss_is_read_q;
        rr_ptr_d      = rr_ptr_q;
        arb_en        = 1'b0;
        drain_done_c  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.drain_req) state_d = StDrain;
                else               arb_en  = 1'b1;
            end
            StHold: begin
                if (bus.drain_req) begin
                    state_d = StDrain;
                    if (hs) iss_valid_d = 1'b0;
                end else if (hs) begin
                    arb_en = 1'b1;
                end
            end
            StDrain: begin
                if (hs) iss_valid_d = 1'b0;
                if (!iss_valid_q && all_idle) begin
                    state_d      = StIdle;
                    drain_done_c = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (arb_en) begin
            if (any_gnt) begin
                iss_valid_d   = 1'b1;
                iss_ptr_d     = bus.ch_req_ptr[win*PTR_WIDTH +: PTR_WIDTH];
                iss_ch_id_d   = win;
                iss_is_read_d = bus.ch_req_is_read[win];
                rr_ptr_d      = (win == ch_id_t'(CHANNEL_NUM - 1)) ? '0 : win + 2'd1;
                state_d       = StHold;
            end else begin
                iss_valid_d = 1'b0;
                state_d     = StIdle;
            end
        end
    end

    always_comb begin
        inc_vec  = '0;
        rsp_vec  = '0;
        all_idle = 1'b1;
        err_d    = err_q;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            inc_vec[c] = hs & iss_is_read_q & (iss_ch_id_q == ch_id_t'(c));
            rsp_vec[c] = bus.rsp_valid & (bus.rsp_ch_id == ch_id_t'(c));
            outst_d[c] = outst_q[c];
            if (outst_q[c] != '0) all_idle = 1'b0;
            if (inc_vec[c] && !rsp_vec[c]) begin
                outst_d[c] = outst_q[c] + 4'd1;
            end else if (!inc_vec[c] && rsp_vec[c]) begin
                // A response with nothing outstanding holds the count and flags the error.
                if (outst_q[c] != '0) outst_d[c] = outst_q[c] - 4'd1;
                else                  err_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            iss_valid_q   <= 1'b0;
            iss_ptr_q     <= '0;
            iss_ch_id_q   <= '0;
            iss_is_read_q <= 1'b0;
            rr_ptr_q      <= '0;
            release_q     <= '0;
            err_q         <= 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++) outst_q[c] <= '0;
        end else begin
            state_q       <= state_d;
            iss_valid_q   <= iss_valid_d;
            iss_ptr_q     <= iss_ptr_d;
            iss_ch_id_q   <= iss_ch_id_d;
            iss_is_read_q <= iss_is_read_d;
            rr_ptr_q      <= rr_ptr_d;
            release_q     <= rsp_vec;
            err_q         <= err_d;
            for (int c = 0; c < CHANNEL_NUM; c++) outst_q[c] <= outst_d[c];
        end
    end

    assign bus.iss_valid               = iss_valid_q;
    assign bus.iss_ptr                 = iss_ptr_q;
    assign bus.iss_ch_id               = iss_ch_id_q;
    assign bus.iss_is_read             = iss_is_read_q;
    assign bus.iq_dequeue              = hs;
    assign bus.iq_dequeue_ptr          = iss_ptr_q;
    assign bus.channels_credit_release = release_q;
    assign bus.drain_done              = drain_done_c;
    assign bus.err_underflow           = err_q;
endmodule

// File: tb/tb_bank_isu_dispatch_sched.sv
// Bench for bank_isu_dispatch_sched: arbitration table plus hand-written multi-cycle sequences,
// with issued commands checked against an expectation queue.
module tb_bank_isu_dispatch_sched;
    import bank_isu_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] ptr;
        logic       rd;
    } exp_t;

    typedef struct {
        logic [2:0] valid;
        logic [2:0] rd;
        logic       exp_v;
        logic [1:0] exp_ch;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] ptrs [3];
    exp_t sb_q [$];
    vec_t vecs [10];
    int   total = 0;
    int   bad   = 0;

    bank_isu_dispatch_sched_if bus();

    bank_isu_dispatch_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign bus.ch_req_ptr = {ptrs[2], ptrs[1], ptrs[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int c, input logic rd);
        sb_q.push_back('{ch: 2'(c), ptr: ptrs[c], rd: rd});
    endtask

    task automatic set_ptrs();
        ptrs[0] = 8'hA0;
        ptrs[1] = 8'hB1;
        ptrs[2] = 8'hC2;
    endtask

    // Samples the dequeue at the falling edge, then moves to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.iq_dequeue) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: dequeue ch=%0d ptr=%0h, none required",
                         bus.iss_ch_id, bus.iss_ptr);
            end else begin
                e = sb_q.pop_front();
                chk("sb_ch", 32'(bus.iss_ch_id), 32'(e.ch));
                chk("sb_ptr", 32'(bus.iss_ptr), 32'(e.ptr));
                chk("sb_rd", 32'(bus.iss_is_read), 32'(e.rd));
                chk("sb_deq_ptr", 32'(bus.iq_dequeue_ptr), 32'(e.ptr));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3'b111, 3'b000, 1'b1, 2'd0};
        vecs[1] = '{3'b111, 3'b000, 1'b1, 2'd1};
        vecs[2] = '{3'b111, 3'b000, 1'b1, 2'd2};
        vecs[3] = '{3'b110, 3'b000, 1'b1, 2'd1};
        vecs[4] = '{3'b011, 3'b000, 1'b1, 2'd0};
        vecs[5] = '{3'b000, 3'b000, 1'b0, 2'd0};
        vecs[6] = '{3'b101, 3'b000, 1'b1, 2'd2};
        vecs[7] = '{3'b001, 3'b001, 1'b1, 2'd0};
        vecs[8] = '{3'b011, 3'b011, 1'b1, 2'd1};
        vecs[9] = '{3'b100, 3'b000, 1'b1, 2'd2};

        rst_n              = 1'b0;
        bus.ch_req_valid   = '0;
        bus.ch_req_is_read = '0;
        bus.iss_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.rsp_ch_id      = '0;
        bus.drain_req      = 1'b0;
        set_ptrs();
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_iss_valid", 32'(bus.iss_valid), 0);
        chk("rst_iss_ptr", 32'(bus.iss_ptr), 0);
        chk("rst_iss_ch_id", 32'(bus.iss_ch_id), 0);
        chk("rst_iss_is_read", 32'(bus.iss_is_read), 0);
        chk("rst_release", 32'(bus.channels_credit_release), 0);
        chk("rst_drain_done", 32'(bus.drain_done), 0);
        chk("rst_err", 32'(bus.err_underflow), 0);
        chk("rst_dequeue", 32'(bus.iq_dequeue), 0);
        rst_n = 1'b1;
        tick();

        // Single-candidate-set arbitration from IDLE; rr pointer carries across rows.
        for (int i = 0; i < 10; i++) begin
            bus.ch_req_valid   = vecs[i].valid;
            bus.ch_req_is_read = vecs[i].rd;
            bus.iss_ready      = 1'b0;
            if (vecs[i].exp_v) push(int'(vecs[i].exp_ch), vecs[i].rd[vecs[i].exp_ch]);
            tick();
            chk("tab_valid", 32'(bus.iss_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) chk("tab_ch", 32'(bus.iss_ch_id), 32'(vecs[i].exp_ch));
            bus.ch_req_valid = '0;
            bus.iss_ready    = 1'b1;
            tick();
            bus.iss_ready = 1'b0;
        end
        bus.rsp_valid = 1'b1;
        bus.rsp_ch_id = 2'd0;
        tick();
        chk("rel_ch0", 32'(bus.channels_credit_release), 32'h1);
        bus.rsp_ch_id = 2'd1;
        tick();
        chk("rel_ch1", 32'(bus.channels_credit_release), 32'h2);
        bus.rsp_valid = 1'b0;
        tick();
        chk("rel_none", 32'(bus.channels_credit_release), 0);

        // Full throughput alternating ch0/ch2.
        bus.ch_req_valid   = 3'b101;
        bus.ch_req_is_read = 3'b000;
        bus.iss_ready      = 1'b1;
        for (int k = 0; k < 6; k++) push((k % 2 == 0) ? 0 : 2, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("tput_dequeue", 32'(bus.iq_dequeue), 1);
        end
        bus.ch_req_valid = '0;
        tick();
        chk("tput_sb_empty", 32'(sb_q.size()), 0);
        chk("tput_idle", 32'(bus.iss_valid), 0);

        // Single read channel: 1 per 2 cycles, stops at the outstanding limit.
        ptrs[1]            = 8'h5B;
        bus.ch_req_valid   = 3'b010;
        bus.ch_req_is_read = 3'b010;
        for (int k = 0; k < 8; k++) push(1, 1'b1);
        for (int k = 0; k < 20; k++) tick();
        chk("lim_sb_empty", 32'(sb_q.size()), 0);
        chk("lim_stalled", 32'(bus.iss_valid), 0);
        push(1, 1'b1);
        bus.rsp_valid = 1'b1;
        bus.rsp_ch_id = 2'd1;
        tick();
        chk("lim_release", 32'(bus.channels_credit_release), 32'h2);
        bus.rsp_valid = 1'b0;
        tick();
        chk("lim_reissue", 32'(bus.iss_valid), 1);
        bus.ch_req_valid = '0;
        tick();
        chk("lim_idle", 32'(bus.iss_valid), 0);
        bus.rsp_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("lim_drain_rel", 32'(bus.channels_credit_release), 32'h2);
        end
        bus.rsp_valid = 1'b0;
        tick();
        chk("lim_no_err", 32'(bus.err_underflow), 0);
        chk("lim_rel_off", 32'(bus.channels_credit_release), 0);

        // Held command stays stable while candidates change.
        set_ptrs();
        ptrs[0]            = 8'h11;
        bus.ch_req_valid   = 3'b001;
        bus.ch_req_is_read = 3'b000;
        bus.iss_ready      = 1'b0;
        push(0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.ch_req_valid = 3'b111;
            ptrs[0] = 8'h40 + 8'(k);
            ptrs[2] = 8'h60 + 8'(k);
            chk("hold_valid", 32'(bus.iss_valid), 1);
            chk("hold_ptr", 32'(bus.iss_ptr), 32'h11);
            chk("hold_ch", 32'(bus.iss_ch_id), 0);
            chk("hold_no_deq", 32'(bus.iq_dequeue), 0);
            tick();
        end
        bus.ch_req_valid = '0;
        bus.iss_ready    = 1'b1;
        tick();
        chk("hold_released", 32'(bus.iss_valid), 0);
        chk("hold_sb_empty", 32'(sb_q.size()), 0);

        // Underflow on ch2.
        bus.rsp_valid = 1'b1;
        bus.rsp_ch_id = 2'd2;
        tick();
        chk("uf_err", 32'(bus.err_underflow), 1);
        chk("uf_release", 32'(bus.channels_credit_release), 32'h4);
        bus.rsp_valid = 1'b0;
        tick();
        chk("uf_sticky", 32'(bus.err_underflow), 1);
        chk("uf_rel_off", 32'(bus.channels_credit_release), 0);

        // Drain with three reads outstanding.
        set_ptrs();
        bus.ch_req_valid   = 3'b111;
        bus.ch_req_is_read = 3'b111;
        push(1, 1'b1);
        push(2, 1'b1);
        push(0, 1'b1);
        tick();
        tick();
        bus.ch_req_valid = 3'b001;
        tick();
        bus.ch_req_valid = 3'b000;
        tick();
        bus.drain_req      = 1'b1;
        bus.ch_req_valid   = 3'b111;
        bus.ch_req_is_read = 3'b000;
        tick();
        bus.drain_req = 1'b0;
        chk("dr_no_issue", 32'(bus.iss_valid), 0);
        chk("dr_not_done", 32'(bus.drain_done), 0);
        tick();
        bus.drain_req = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_ch_id = 2'd0;
        chk("dr_no_issue2", 32'(bus.iss_valid), 0);
        tick();
        bus.drain_req = 1'b0;
        bus.rsp_ch_id = 2'd1;
        tick();
        bus.rsp_ch_id = 2'd2;
        chk("dr_wait", 32'(bus.drain_done), 0);
        tick();
        bus.rsp_valid = 1'b0;
        chk("dr_done", 32'(bus.drain_done), 1);
        chk("dr_rel2", 32'(bus.channels_credit_release), 32'h4);
        tick();
        chk("dr_done_pulse", 32'(bus.drain_done), 0);
        chk("dr_idle", 32'(bus.iss_valid), 0);
        push(1, 1'b0);
        tick();
        chk("dr_resume", 32'(bus.iss_valid), 1);
        bus.ch_req_valid = '0;
        tick();
        chk("dr_resume_done", 32'(bus.iss_valid), 0);
        chk("dr_sb_empty", 32'(sb_q.size()), 0);

        // Reset in HOLD with four reads outstanding.
        bus.ch_req_valid   = 3'b101;
        bus.ch_req_is_read = 3'b101;
        push(2, 1'b1);
        push(0, 1'b1);
        push(2, 1'b1);
        push(0, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        bus.iss_ready    = 1'b0;
        bus.ch_req_valid = '0;
        chk("rh_hold", 32'(bus.iss_valid), 1);
        rst_n = 1'b0;
        tick();
        chk("rh_valid", 32'(bus.iss_valid), 0);
        chk("rh_ptr", 32'(bus.iss_ptr), 0);
        chk("rh_ch", 32'(bus.iss_ch_id), 0);
        chk("rh_rd", 32'(bus.iss_is_read), 0);
        chk("rh_err", 32'(bus.err_underflow), 0);
        chk("rh_release", 32'(bus.channels_credit_release), 0);
        rst_n         = 1'b1;
        bus.drain_req = 1'b1;
        tick();
        bus.drain_req = 1'b0;
        chk("rh_cnt_zero", 32'(bus.drain_done), 1);
        tick();
        chk("rh_after", 32'(bus.drain_done), 0);
        chk("final_sb_empty", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
